ir_fetch_ctrl: RTL and testbench

IR_FETCH_CTRL -- requirements
Module: ir_fetch_ctrl

---
 rtl/ir_fetch_ctrl.sv | 70 +++++++
 tb/tb_ir_fetch_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ir_fetch_ctrl.sv
// rtl/ir_fetch_ctrl.sv - instruction fetch controller with 2-cycle memory tag pipeline
module ir_fetch_ctrl #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_en,
   output logic [ADDR_W-1:0] o_pc,
   output logic              o_valid,
   output logic [15:0]       fetch_cnt
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_pc1;
   logic [ADDR_W-1:0] r_pc2;
   logic              r_v1;
   logic              r_v2;
   logic [15:0]       r_fetch_cnt;
   logic              w_fetch;

   // A redirect cycle never fetches: the old PC is already stale.
   assign w_fetch = (r_state == ST_RUN) && !stall && !redirect;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_BOOT;
         r_pc        <= RESET_PC;
         r_pc1       <= '0;
         r_pc2       <= '0;
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_fetch_cnt <= '0;
      end else begin
         r_state <= stall ? ST_HOLD : ST_RUN;

         if (redirect)
            r_pc <= redirect_pc;
         else if (w_fetch)
            r_pc <= r_pc + 1'b1;

         // Tags advance every cycle so they line up with the fixed read latency.
         r_pc1 <= r_pc;
         r_pc2 <= r_pc1;
         r_v1  <= w_fetch;
         r_v2  <= redirect ? 1'b0 : r_v1;

         if (w_fetch && (r_fetch_cnt != 16'hFFFF))
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
      end
   end

   assign imem_en   = w_fetch;
   assign imem_addr = r_pc;
   assign o_valid   = r_v2;
   assign o_pc      = r_pc2;
   assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// tb/tb_ir_fetch_ctrl.sv - directed-vector bench for ir_fetch_ctrl
module tb_ir_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] imem_addr;
   logic        imem_en;
   logic [15:0] o_pc;
   logic        o_valid;
   logic [15:0] fetch_cnt;

   int n_checks;
   int n_errors;

   ir_fetch_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_en     (imem_en),
      .o_pc        (o_pc),
      .o_valid     (o_valid),
      .fetch_cnt   (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to 2 time units after the next rising edge; inputs are set here.
   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_cycle(input string tag, input logic en, input logic [15:0] addr,
                               input logic vld, input logic [15:0] pc);
      #1;
      check({tag, ".en"},   {31'd0, imem_en}, {31'd0, en});
      check({tag, ".addr"}, {16'd0, imem_addr}, {16'd0, addr});
      check({tag, ".vld"},  {31'd0, o_valid}, {31'd0, vld});
      if (vld)
         check({tag, ".pc"}, {16'd0, o_pc}, {16'd0, pc});
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst         = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;

      repeat (3) next_cycle();
      #1;
      check("rst.en",   {31'd0, imem_en}, 32'd0);
      check("rst.addr", {16'd0, imem_addr}, 32'h0000);
      check("rst.vld",  {31'd0, o_valid}, 32'd0);
      check("rst.opc",  {16'd0, o_pc}, 32'h0000);
      check("rst.cnt",  {16'd0, fetch_cnt}, 32'd0);

      // Release: the remainder of this cycle is BOOT.
      rst = 1'b1;
      expect_cycle("boot", 1'b0, 16'h0000, 1'b0, 16'h0);
      next_cycle(); expect_cycle("c1", 1'b1, 16'h0000, 1'b0, 16'h0);
      next_cycle(); expect_cycle("c2", 1'b1, 16'h0001, 1'b0, 16'h0);
      next_cycle(); expect_cycle("c3", 1'b1, 16'h0002, 1'b1, 16'h0000);
      next_cycle(); expect_cycle("c4", 1'b1, 16'h0003, 1'b1, 16'h0001);
      next_cycle(); expect_cycle("c5", 1'b1, 16'h0004, 1'b1, 16'h0002);

      // Stall three cycles at imem_addr=5; in-flight 3,4 still emerge.
      next_cycle(); stall = 1'b1; expect_cycle("st1", 1'b0, 16'h0005, 1'b1, 16'h0003);
      next_cycle();               expect_cycle("st2", 1'b0, 16'h0005, 1'b1, 16'h0004);
      next_cycle();               expect_cycle("st3", 1'b0, 16'h0005, 1'b0, 16'h0);
      next_cycle(); stall = 1'b0; expect_cycle("hold", 1'b0, 16'h0005, 1'b0, 16'h0);
      next_cycle();               expect_cycle("res5", 1'b1, 16'h0005, 1'b0, 16'h0);
      next_cycle();               expect_cycle("res6", 1'b1, 16'h0006, 1'b0, 16'h0);

      // Redirect while pc_r=7.
      next_cycle(); redirect = 1'b1; redirect_pc = 16'h0100;
      expect_cycle("rd0", 1'b0, 16'h0007, 1'b1, 16'h0005);
      next_cycle(); redirect = 1'b0; expect_cycle("rd1", 1'b1, 16'h0100, 1'b0, 16'h0);
      next_cycle();                  expect_cycle("rd2", 1'b1, 16'h0101, 1'b0, 16'h0);
      next_cycle();                  expect_cycle("rd3", 1'b1, 16'h0102, 1'b1, 16'h0100);
      check("cnt9", {16'd0, fetch_cnt}, 32'd9);

      // Redirect together with stall lands in HOLD at the target.
      next_cycle(); redirect = 1'b1; redirect_pc = 16'hFFFE; stall = 1'b1;
      expect_cycle("rs0", 1'b0, 16'h0103, 1'b1, 16'h0101);
      next_cycle(); redirect = 1'b0; expect_cycle("rs1", 1'b0, 16'hFFFE, 1'b0, 16'h0);
      next_cycle(); stall = 1'b0;    expect_cycle("rs2", 1'b0, 16'hFFFE, 1'b0, 16'h0);
      next_cycle(); expect_cycle("rs3", 1'b1, 16'hFFFE, 1'b0, 16'h0);
      next_cycle(); expect_cycle("wr0", 1'b1, 16'hFFFF, 1'b0, 16'h0);
      next_cycle(); expect_cycle("wr1", 1'b1, 16'h0000, 1'b1, 16'hFFFE);
      next_cycle(); expect_cycle("wr2", 1'b1, 16'h0001, 1'b1, 16'hFFFF);
      next_cycle(); expect_cycle("wr3", 1'b1, 16'h0002, 1'b1, 16'h0000);

      // Asynchronous reset mid-run, sampled before any clock edge.
      next_cycle();
      rst = 1'b0;
      #1;
      check("arst.cnt",  {16'd0, fetch_cnt}, 32'd0);
      check("arst.vld",  {31'd0, o_valid}, 32'd0);
      check("arst.en",   {31'd0, imem_en}, 32'd0);
      check("arst.addr", {16'd0, imem_addr}, 32'h0000);
      check("arst.opc",  {16'd0, o_pc}, 32'h0000);

      // Redirect during BOOT still leaves BOOT after one cycle.
      next_cycle();
      rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
      expect_cycle("bt0", 1'b0, 16'h0000, 1'b0, 16'h0);
      next_cycle(); redirect = 1'b0;
      expect_cycle("bt1", 1'b1, 16'h0040, 1'b0, 16'h0);

      // 70000 more fetches: counter saturates, address wraps.
      repeat (70000) @(posedge clk);
      #3;
      check("sat.cnt",  {16'd0, fetch_cnt}, 32'h0000FFFF);
      check("sat.addr", {16'd0, imem_addr}, 32'h000011B0);
      check("sat.vld",  {31'd0, o_valid}, 32'd1);
      check("sat.opc",  {16'd0, o_pc}, 32'h000011AE);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
